// File: rtl/scl_clamp_release_seq.sv
// scl_clamp_release_seq: power-up sequencer for the pad-ring clamp groups.
// Keeps every clamp group engaged until pwr_good has been continuously high
// for SETTLE cycles. It then releases the groups in ascending order, one group
// every STAGGER cycles. Any supply loss re-engages all groups on the same edge.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   pwr_good     supply-good indication, already synchronised
//   sw_hold      software request to keep or return clamps engaged
//   fault_clr    clears the sticky fault flag
//   clamp_en     per-group clamp enable, 1 = engaged
//   release_done high while all groups are released (RUN)
//   seq_state    0 CLAMP, 1 SETTLE, 2 RELEASE, 3 RUN
//   fault        sticky: supply lost during RELEASE or RUN
module scl_clamp_release_seq #(
    parameter int NGRP    = 4,
    parameter int SETTLE  = 16,
    parameter int STAGGER = 4,
    parameter int CW      = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pwr_good,
    input  logic            sw_hold,
    input  logic            fault_clr,
    output logic [NGRP-1:0] clamp_en,
    output logic            release_done,
    output logic [1:0]      seq_state,
    output logic            fault
);
    localparam logic [1:0] CLAMP   = 2'd0;
    localparam logic [1:0] SETL    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;
    localparam int IW = NGRP > 1 ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] SET_M1 = CW'(SETTLE - 1);
    localparam logic [CW-1:0] STG_M1 = CW'(STAGGER - 1);
    localparam logic [IW-1:0] LAST   = IW'(NGRP - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            clamp_en     <= '1;
            release_done <= 1'b0;
            seq_state    <= CLAMP;
            fault        <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
        end else begin
            // Placed first so that a simultaneous set below takes priority.
            if (fault_clr) fault <= 1'b0;
            case (seq_state)
                CLAMP: begin
                    clamp_en     <= '1;
                    release_done <= 1'b0;
                    if (pwr_good && !sw_hold) begin
                        seq_state <= SETL;
                        cnt       <= '0;
                        idx       <= '0;
                    end
                end
                SETL: begin
                    if (!pwr_good || sw_hold) begin
                        seq_state <= CLAMP;
                        cnt       <= '0;
                    end else if (cnt == SET_M1) begin
                        clamp_en[0]  <= 1'b0;
                        cnt          <= '0;
                        idx          <= IW'(1);
                        seq_state    <= NGRP == 1 ? RUN : RELEASE;
                        release_done <= NGRP == 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!pwr_good) begin
                        seq_state <= CLAMP;
                        clamp_en  <= '1;
                        fault     <= 1'b1;
                        cnt       <= '0;
                        idx       <= '0;
                    end else if (!sw_hold) begin
                        if (cnt == STG_M1) begin
                            // Mask form avoids a variable bit-select on clamp_en.
                            clamp_en <= clamp_en & ~(NGRP'(1) << idx);
                            cnt      <= '0;
                            idx      <= idx + IW'(1);
                            if (idx == LAST) begin
                                seq_state    <= RUN;
                                release_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    if (!pwr_good) begin
                        seq_state    <= CLAMP;
                        clamp_en     <= '1;
                        release_done <= 1'b0;
                        fault        <= 1'b1;
                        cnt          <= '0;
                        idx          <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scl_clamp_release_seq.sv
// tb_scl_clamp_release_seq: directed self-checking bench for the clamp release sequencer.
module tb_scl_clamp_release_seq;
    logic       clock = 1'b0;
    logic       reset, pwr_good, sw_hold, fault_clr;
    logic [3:0] clamp_en;
    logic       release_done, fault;
    logic [1:0] seq_state;
    logic [0:0] clamp1;
    logic       rd1, fault1;
    logic [1:0] st1;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    scl_clamp_release_seq dut (
        .clock(clock), .reset(reset), .pwr_good(pwr_good), .sw_hold(sw_hold),
        .fault_clr(fault_clr), .clamp_en(clamp_en), .release_done(release_done),
        .seq_state(seq_state), .fault(fault)
    );

    scl_clamp_release_seq #(.NGRP(1), .SETTLE(3), .STAGGER(4), .CW(8)) dut1 (
        .clock(clock), .reset(reset), .pwr_good(pwr_good), .sw_hold(sw_hold),
        .fault_clr(fault_clr), .clamp_en(clamp1), .release_done(rd1),
        .seq_state(st1), .fault(fault1)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic r,
                           input logic [1:0] s, input logic f);
        chk({tag, "_clamp"}, clamp_en, c);
        chk({tag, "_done"}, release_done, r);
        chk({tag, "_state"}, seq_state, s);
        chk({tag, "_fault"}, fault, f);
    endtask

    initial begin
        reset = 1'b1; pwr_good = 1'b0; sw_hold = 1'b0; fault_clr = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_all("reset", 4'b1111, 1'b0, 2'd0, 1'b0);
        chk("reset_u1_clamp", clamp1, 1'b1);

        // Nominal sequence; edge 0 is the first edge sampling pwr_good=1.
        pwr_good = 1'b1;
        tick();
        chk("nom_e0_state", seq_state, 2'd1);
        tick(2);
        chk("u1_e2_clamp", clamp1, 1'b1);
        chk("u1_e2_state", st1, 2'd1);
        tick();
        chk("u1_e3_clamp", clamp1, 1'b0);
        chk("u1_e3_done", rd1, 1'b1);
        chk("u1_e3_state", st1, 2'd3);
        tick(12);
        chk_all("nom_e15", 4'b1111, 1'b0, 2'd1, 1'b0);
        tick();
        chk_all("nom_e16", 4'b1110, 1'b0, 2'd2, 1'b0);
        tick(3);
        chk("nom_e19_clamp", clamp_en, 4'b1110);
        tick();
        chk("nom_e20_clamp", clamp_en, 4'b1100);
        tick(4);
        chk("nom_e24_clamp", clamp_en, 4'b1000);
        tick(3);
        chk_all("nom_e27", 4'b1000, 1'b0, 2'd2, 1'b0);
        tick();
        chk_all("nom_e28", 4'b0000, 1'b1, 2'd3, 1'b0);

        // sw_hold is ignored in RUN.
        sw_hold = 1'b1;
        tick(3);
        chk_all("run_hold", 4'b0000, 1'b1, 2'd3, 1'b0);
        sw_hold = 1'b0;

        // Supply loss in RUN with a coincident fault_clr: set wins.
        pwr_good = 1'b0; fault_clr = 1'b1;
        tick();
        chk_all("race", 4'b1111, 1'b0, 2'd0, 1'b1);
        fault_clr = 1'b0;
        tick();
        chk("race_hold_fault", fault, 1'b1);
        fault_clr = 1'b1;
        tick();
        chk("clr_fault", fault, 1'b0);
        fault_clr = 1'b0;

        // Settle glitch: one low sample at settle edge 10 restarts the interval.
        pwr_good = 1'b1;
        tick();
        chk("gl_e0_state", seq_state, 2'd1);
        tick(9);
        pwr_good = 1'b0;
        tick();
        chk_all("gl_drop", 4'b1111, 1'b0, 2'd0, 1'b0);
        pwr_good = 1'b1;
        tick();
        chk("gl_restart_state", seq_state, 2'd1);
        tick(15);
        chk_all("gl_e15", 4'b1111, 1'b0, 2'd1, 1'b0);
        tick();
        chk_all("gl_e16", 4'b1110, 1'b0, 2'd2, 1'b0);

        // Hold pause: 2 cycles after group 0, hold for 5 edges.
        tick(2);
        sw_hold = 1'b1;
        tick(5);
        chk_all("hold_paused", 4'b1110, 1'b0, 2'd2, 1'b0);
        sw_hold = 1'b0;
        tick();
        chk("hold_e24_clamp", clamp_en, 4'b1110);
        tick();
        chk_all("hold_e25", 4'b1100, 1'b0, 2'd2, 1'b0);

        // Brown-out in RELEASE after group 1 released.
        pwr_good = 1'b0;
        tick();
        chk_all("brown", 4'b1111, 1'b0, 2'd0, 1'b1);
        pwr_good = 1'b1;
        tick();
        chk_all("rerun_e0", 4'b1111, 1'b0, 2'd1, 1'b1);
        tick(16);
        chk_all("rerun_e16", 4'b1110, 1'b0, 2'd2, 1'b1);
        tick(12);
        chk_all("rerun_e28", 4'b0000, 1'b1, 2'd3, 1'b1);

        // Reset in RELEASE overrides everything, including pwr_good=1.
        pwr_good = 1'b0;
        tick();
        pwr_good = 1'b1;
        tick();
        tick(20);
        chk_all("pre_rst", 4'b1100, 1'b0, 2'd2, 1'b1);
        reset = 1'b1;
        tick();
        chk_all("mid_rst", 4'b1111, 1'b0, 2'd0, 1'b0);
        chk("mid_rst_u1_clamp", clamp1, 1'b1);
        chk("mid_rst_u1_done", rd1, 1'b0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
